// File: rtl/ahb_protocol_checker.sv
// Passive AHB protocol checker for one master/slave pair.
// It tracks bursts, wait states and error responses on the bus.
// Each violation produces a one-cycle err_valid pulse with the lowest violated
// check index on err_code, and sets a bit in the sticky error vector.
// Violation flags are registered once and then once more, so err_valid, err_code
// and err_sticky appear one edge after the edge at which the violation was seen.
module ahb_protocol_checker #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 16,
    parameter int NCHK     = 10
) (
    input  logic            hclk,
    input  logic            HRESETn,
    input  logic            chk_en,
    input  logic            clr_sticky,
    input  logic [1:0]      HTRANS,
    input  logic [AW-1:0]   HADDR,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [2:0]      HBURST,
    input  logic            HREADY,
    input  logic [1:0]      HRESP,
    output logic            err_valid,
    output logic [3:0]      err_code,
    output logic [NCHK-1:0] err_sticky,
    output logic [4:0]      beat_cnt,
    output logic            burst_act
);

    localparam logic [2:0]    MAX_SIZE   = 3'($clog2(DW / 8));
    localparam int            WW         = $clog2(MAX_WAIT + 2);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_SAT   = WW'(MAX_WAIT + 1);
    localparam logic [1:0]    TR_IDLE    = 2'b00;
    localparam logic [1:0]    TR_BUSY    = 2'b01;
    localparam logic [1:0]    TR_NONSEQ  = 2'b10;
    localparam logic [1:0]    TR_SEQ     = 2'b11;
    localparam logic [1:0]    RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BURST = 2'b01,
        ST_RESP2 = 2'b10
    } state_t;

    state_t          state_r;
    logic [AW-1:0]   addr_r;
    logic [2:0]      size_r;
    logic            write_r;
    logic [2:0]      burst_r;
    logic [AW-1:0]   prev_addr_r;
    logic [1:0]      prev_trans_r;
    logic [2:0]      prev_size_r;
    logic            prev_write_r;
    logic [2:0]      prev_burst_r;
    logic            prev_ready_r;
    logic [1:0]      prev_resp_r;
    logic [1:0]      resp_r;
    logic [WW-1:0]   wait_r;
    logic [NCHK-1:0] fail_r;

    logic            acc_s;
    logic            is_idle_s;
    logic            is_busy_s;
    logic            is_nonseq_s;
    logic            is_seq_s;
    logic            fixed_s;
    logic            wrap_s;
    logic            last_beat_s;
    logic [4:0]      nbeats_s;
    logic [AW-1:0]   exp_addr_s;
    logic [AW-1:0]   align_mask_s;
    logic [NCHK-1:0] fail_s;

    // Address that follows prev within an INCR or WRAP burst.
    // A WRAP burst wraps at a boundary of (beats << size) bytes.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] prev,
                                                input logic [2:0] size,
                                                input logic [2:0] burst);
        logic [AW-1:0] step_v;
        logic [AW-1:0] inc_v;
        logic [AW-1:0] wmask_v;
        step_v  = AW'(1'b1) << size;
        inc_v   = prev + step_v;
        wmask_v = (step_v << ({1'b0, burst[2:1]} + 3'd1)) - AW'(1'b1);
        return (burst[2:1] != 2'b00 && !burst[0]) ?
               ((prev & ~wmask_v) | (inc_v & wmask_v)) : inc_v;
    endfunction

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [3:0] lowest_set(input logic [NCHK-1:0] v);
        logic [3:0] idx_v;
        idx_v = 4'd0;
        for (int i = NCHK - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx_v = 4'(i);
            end else begin
                idx_v = idx_v;
            end
        end
        return idx_v;
    endfunction

    assign is_idle_s   = (HTRANS == TR_IDLE);
    assign is_busy_s   = (HTRANS == TR_BUSY);
    assign is_nonseq_s = (HTRANS == TR_NONSEQ);
    assign is_seq_s    = (HTRANS == TR_SEQ);
    assign acc_s       = HREADY && HTRANS[1];
    assign fixed_s     = (burst_r[2:1] != 2'b00);
    assign wrap_s      = fixed_s && !burst_r[0];
    assign last_beat_s = fixed_s && (beat_cnt == nbeats_s);
    assign exp_addr_s  = next_addr(addr_r, size_r, burst_r);

    // Beat count of the saved fixed-length burst type.
    always_comb begin
        nbeats_s = 5'd16;
        case (burst_r[2:1])
            2'b01:   nbeats_s = 5'd4;
            2'b10:   nbeats_s = 5'd8;
            2'b11:   nbeats_s = 5'd16;
            default: nbeats_s = 5'd16;
        endcase
    end

    // Evaluate every protocol check against the current bus sample.
    always_comb begin
        fail_s       = '0;
        align_mask_s = (AW'(1'b1) << HSIZE) - AW'(1'b1);
        fail_s[0] = HREADY && (is_seq_s || is_busy_s) && (state_r == ST_IDLE);
        fail_s[1] = HREADY && (is_seq_s || is_busy_s) && (state_r == ST_BURST) &&
                    ((HSIZE != size_r) || (HWRITE != write_r) || (HBURST != burst_r));
        fail_s[2] = acc_s && is_seq_s && (state_r == ST_BURST) && !last_beat_s &&
                    (HADDR != exp_addr_s);
        fail_s[3] = acc_s && ((HADDR & align_mask_s) != '0);
        fail_s[4] = !HREADY && (wait_r == WAIT_LIMIT);
        fail_s[5] = HREADY && (HRESP == RESP_OKAY) && (state_r == ST_BURST) && fixed_s &&
                    ((is_seq_s && (beat_cnt == nbeats_s)) ||
                     ((is_nonseq_s || is_idle_s) && (beat_cnt < nbeats_s)));
        fail_s[6] = !prev_ready_r && (prev_resp_r == RESP_OKAY) &&
                    ((HADDR != prev_addr_r) || (HSIZE != prev_size_r) ||
                     (HWRITE != prev_write_r) || (HBURST != prev_burst_r) ||
                     ((HTRANS != prev_trans_r) && !((prev_trans_r == TR_BUSY) && is_seq_s)));
        if (state_r == ST_RESP2) begin
            fail_s[7] = !HREADY || (HRESP != resp_r);
        end else begin
            fail_s[7] = HREADY && (HRESP != RESP_OKAY);
        end
        fail_s[8] = acc_s && (HSIZE > MAX_SIZE);
        fail_s[9] = acc_s && is_seq_s && (state_r == ST_BURST) && !wrap_s &&
                    (HADDR[10] != addr_r[10]);
    end

    // Burst/response state machine with the beat counter and burst flag.
    always_ff @(posedge hclk or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r   <= ST_IDLE;
            beat_cnt  <= 5'd0;
            burst_act <= 1'b0;
            resp_r    <= RESP_OKAY;
        end else if ((HRESP != RESP_OKAY) && !HREADY) begin
            state_r   <= ST_RESP2;
            beat_cnt  <= 5'd0;
            burst_act <= 1'b0;
            resp_r    <= HRESP;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (acc_s && is_nonseq_s && (HBURST != 3'b000)) begin
                        state_r   <= ST_BURST;
                        beat_cnt  <= 5'd1;
                        burst_act <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (!HREADY) begin
                        state_r <= ST_BURST;
                    end else if (is_nonseq_s) begin
                        state_r   <= (HBURST != 3'b000) ? ST_BURST : ST_IDLE;
                        beat_cnt  <= (HBURST != 3'b000) ? 5'd1 : 5'd0;
                        burst_act <= (HBURST != 3'b000);
                    end else if (is_idle_s || last_beat_s) begin
                        state_r   <= ST_IDLE;
                        beat_cnt  <= 5'd0;
                        burst_act <= 1'b0;
                    end else if (is_seq_s && (beat_cnt != 5'd16)) begin
                        beat_cnt <= beat_cnt + 5'd1;
                    end
                end
                ST_RESP2: begin
                    state_r   <= ST_IDLE;
                    beat_cnt  <= 5'd0;
                    burst_act <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    beat_cnt  <= 5'd0;
                    burst_act <= 1'b0;
                end
            endcase
        end
    end

    // Save the accepted transfer, the previous bus sample, and the wait-state count.
    always_ff @(posedge hclk or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_r       <= '0;
            size_r       <= 3'd0;
            write_r      <= 1'b0;
            burst_r      <= 3'd0;
            prev_addr_r  <= '0;
            prev_trans_r <= TR_IDLE;
            prev_size_r  <= 3'd0;
            prev_write_r <= 1'b0;
            prev_burst_r <= 3'd0;
            prev_ready_r <= 1'b1;
            prev_resp_r  <= RESP_OKAY;
            wait_r       <= '0;
        end else begin
            if (acc_s) begin
                addr_r  <= HADDR;
                size_r  <= HSIZE;
                write_r <= HWRITE;
                burst_r <= HBURST;
            end
            prev_addr_r  <= HADDR;
            prev_trans_r <= HTRANS;
            prev_size_r  <= HSIZE;
            prev_write_r <= HWRITE;
            prev_burst_r <= HBURST;
            prev_ready_r <= HREADY;
            prev_resp_r  <= HRESP;
            if (HREADY) begin
                wait_r <= '0;
            end else if (wait_r != WAIT_SAT) begin
                wait_r <= wait_r + WW'(1'b1);
            end
        end
    end

    // Register gated violations, then drive the pulse, the code and the sticky vector.
    always_ff @(posedge hclk or negedge HRESETn) begin
        if (!HRESETn) begin
            fail_r     <= '0;
            err_valid  <= 1'b0;
            err_code   <= 4'd0;
            err_sticky <= '0;
        end else begin
            fail_r     <= chk_en ? fail_s : '0;
            err_valid  <= |fail_r;
            err_code   <= lowest_set(fail_r);
            err_sticky <= (clr_sticky ? '0 : err_sticky) | fail_r;
        end
    end

endmodule
